uart_result_encoder: RTL and testbench
======================================

Name: uart_result_encoder

Overview:
Serialises one calculator result into an ASCII response frame for the UART transmitter. It is the return path of the command decoder. It captures a result, data type and error flag on a start pulse. It then emits the frame one byte at a time over a valid/ready byte handshake to the UART TX block, and pulses done when the last byte is accepted.

Parameters:
DIGITS, 8, number of hex nibbles emitted; result width RES_W = 4*DIGITS.

Ports:
clk  input  1  clock
n_rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle request; captures result/dtype/err; ignored while busy=1
result  input  RES_W  calculation result, two's complement when dtype=signed
dtype  input  4  4'h1 unsigned, 4'h2 signed; any other value is treated as unsigned
err  input  1  calculation error (e.g. divide by zero)
tx_data  output  8  ASCII byte to the UART TX block
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts the byte this cycle
busy  output  1  frame in progress (start captured, final byte not yet accepted)
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset values: tx_data=8'h00, tx_valid=0, busy=0, done=0, state=IDLE, all capture registers 0.
- Frame formats:
  - Normal: 'O'(4F) ' '(20) [sign] DIGITS hex chars, MSB nibble first, then CR(0D) LF(0A).
  - err=1: 'O'(4F) ' '(20) 'E'(45) CR LF. Sign and digits are skipped.
- Sign and magnitude:
  - Signed with result[RES_W-1]=1: emit '-'(2D); magnitude = two's complement negation, computed at capture.
  - Signed and non-negative: emit '+'(2B).
  - Unsigned: no sign byte.
  - The most-negative value negates to itself and prints e.g. "80000000"; this is correct.
- Nibble to ASCII: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10), uppercase only.
- Handshake:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays 1.
  - tx_valid never drops mid-frame.
  - tx_valid may be asserted with tx_ready low.
- Latency:
  - start sampled high at edge N -> busy=1, tx_valid=1, tx_data=4F from edge N (registered outputs).
  - With tx_ready held at 1, one byte transfers per cycle, with no bubbles between bytes.
- FSM: IDLE -> HEAD(4F) -> SPACE(20) -> {ERR(45) | SIGN | DIGIT} -> CR -> LF -> IDLE.
  - HEAD, SPACE, ERR, SIGN and CR each advance on handshake.
  - SIGN is entered only for signed results.
  - DIGIT loops DIGITS times using a down-counter loaded with DIGITS-1 and a left-shift of the captured magnitude by 4 per handshake. It exits to CR on the handshake at count 0.
  - LF handshake -> IDLE: busy=0, tx_valid=0, and done=1 on the following cycle only.
- start while busy: ignored; captured values are unchanged.
- start in the same cycle that done is high: accepted (busy already 0).
- Reset asserted mid-frame: all outputs return to reset values immediately. No partial frame resumes.

Decomposition:
- Shared package calc_pkg:
  - ASCII constants: 'I', 'O', 'E', space, '=', '+', '-', '*', '/', CR, LF, '0', 'A'.
  - dtype codes: DT_UNSIGNED=4'h1, DT_SIGNED=4'h2.
  - op codes: ADD=5'h01, SUB=5'h02, MUL=5'h04, DIV=5'h08.
  - Encoder state encoding.
- One combinational sub-module, calc_nib2ascii: 4-bit in, 8-bit ASCII out; reusable by other blocks.

Test Plan:
- Unsigned: result=32'h0001E240, dtype=1, tx_ready=1 -> bytes 4F 20 30 30 30 31 45 32 34 30 0D 0A on 12 consecutive cycles; done pulses once on cycle 13.
- Signed negative: result=32'hFFFFFFFB, dtype=2 -> 4F 20 2D 30 30 30 30 30 30 30 35 0D 0A. Signed result=32'h0000000C -> 4F 20 2B 30 30 30 30 30 30 30 43 0D 0A.
- Error: err=1, result=32'h12345678 -> exactly 4F 20 45 0D 0A, then done.
- Backpressure: tx_ready random with 50% duty -> the same byte sequence as with no backpressure; tx_data stays stable while tx_valid=1 and tx_ready=0; no byte is dropped or duplicated.
- start pulsed mid-frame with different result -> the current frame completes unchanged and no second frame follows. A start on the done cycle -> a second frame begins on the next cycle.
- n_rst asserted after the 5th byte -> tx_valid=0, busy=0, done=0 immediately. After release, a new start produces a full correct frame beginning with 4F.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ASCII bytes, dtype and opcode values,
// and the result-encoder state encoding.
package calc_pkg;

    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_O     = 8'h4F;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;
    localparam logic [7:0] ASC_SLASH = 8'h2F;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;

    localparam logic [3:0] DT_UNSIGNED = 4'h1;
    localparam logic [3:0] DT_SIGNED   = 4'h2;

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MUL = 5'h04;
    localparam logic [4:0] OP_DIV = 5'h08;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HEAD  = 3'd1;
    localparam logic [2:0] ST_SPACE = 3'd2;
    localparam logic [2:0] ST_ERR   = 3'd3;
    localparam logic [2:0] ST_SIGN  = 3'd4;
    localparam logic [2:0] ST_DIGIT = 3'd5;
    localparam logic [2:0] ST_CR    = 3'd6;
    localparam logic [2:0] ST_LF    = 3'd7;

endpackage

// File: rtl/calc_nib2ascii.sv
// Converts one hex nibble to its uppercase ASCII character.
module calc_nib2ascii
    import calc_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            ascii_o = ASC_0 + {4'h0, nib_i};
        end else begin
            ascii_o = ASC_A + {4'h0, nib_i - 4'd10};
        end
    end

endmodule

// File: rtl/uart_result_encoder.sv
// Serialises a captured calculator result into an ASCII response frame,
// one byte per valid/ready handshake, pulsing done after the final LF.
module uart_result_encoder
    import calc_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   result,
    input  logic [3:0]            dtype,
    input  logic                  err,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int RES_W = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIGITS - 1);

    logic [2:0]       state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RES_W-1:0] mag_q, mag_d;
    logic             err_q, err_d;
    logic             sgn_q, sgn_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             xfer;
    logic             in_signed;
    logic             in_neg;
    logic [RES_W-1:0] mag_shift;
    logic [3:0]       nib;
    logic [7:0]       nib_ascii;

    assign xfer      = tx_valid_q && tx_ready;
    assign in_signed = (dtype == DT_SIGNED);
    assign in_neg    = in_signed && result[RES_W-1];
    assign mag_shift = mag_q << 4;

    // Entering DIGIT shows the top nibble; inside DIGIT the next byte is
    // the nibble below it, which becomes the top once mag shifts.
    assign nib = (state_q == ST_DIGIT) ? mag_shift[RES_W-1 -: 4] : mag_q[RES_W-1 -: 4];

    calc_nib2ascii u_nib2ascii (
        .nib_i   (nib),
        .ascii_o (nib_ascii)
    );

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path
        // through the case statement can infer a latch.
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mag_d      = mag_q;
        err_d      = err_q;
        sgn_d      = sgn_q;
        neg_d      = neg_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mag_d      = in_neg ? (~result + RES_W'(1)) : result;
                    err_d      = err;
                    sgn_d      = in_signed;
                    neg_d      = in_neg;
                    state_d    = ST_HEAD;
                    tx_data_d  = ASC_O;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_HEAD: begin
                if (xfer) begin
                    state_d   = ST_SPACE;
                    tx_data_d = ASC_SPACE;
                end
            end
            ST_SPACE: begin
                if (xfer) begin
                    if (err_q) begin
                        state_d   = ST_ERR;
                        tx_data_d = ASC_E;
                    end else if (sgn_q) begin
                        state_d   = ST_SIGN;
                        tx_data_d = neg_q ? ASC_MINUS : ASC_PLUS;
                    end else begin
                        state_d   = ST_DIGIT;
                        tx_data_d = nib_ascii;
                        cnt_d     = CNT_LOAD;
                    end
                end
            end
            ST_SIGN: begin
                if (xfer) begin
                    state_d   = ST_DIGIT;
                    tx_data_d = nib_ascii;
                    cnt_d     = CNT_LOAD;
                end
            end
            ST_DIGIT: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        state_d   = ST_CR;
                        tx_data_d = ASC_CR;
                    end else begin
                        mag_d     = mag_shift;
                        cnt_d     = cnt_q - CNT_W'(1);
                        tx_data_d = nib_ascii;
                    end
                end
            end
            ST_ERR: begin
                if (xfer) begin
                    state_d   = ST_CR;
                    tx_data_d = ASC_CR;
                end
            end
            ST_CR: begin
                if (xfer) begin
                    state_d   = ST_LF;
                    tx_data_d = ASC_LF;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    state_d    = ST_IDLE;
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mag_q      <= '0;
            err_q      <= 1'b0;
            sgn_q      <= 1'b0;
            neg_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mag_q      <= mag_d;
            err_q      <= err_d;
            sgn_q      <= sgn_d;
            neg_q      <= neg_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_result_encoder.sv
// Randomised bench for uart_result_encoder against a frame-level model that
// builds the expected byte string directly from result, dtype and err.
module tb_uart_result_encoder;

    localparam int DIGITS = 8;
    localparam int RES_W  = 4 * DIGITS;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic [RES_W-1:0] result;
    logic [3:0]       dtype;
    logic             err;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    uart_result_encoder #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .result   (result),
        .dtype    (dtype),
        .err      (err),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Expected frame as a string of "hh " byte tokens.
    function automatic string model(input logic [RES_W-1:0] r, input logic [3:0] dt, input logic e);
        string       s;
        logic [RES_W-1:0] mag;
        int          n;
        s = "4f 20 ";
        if (e) begin
            s = {s, "45 "};
        end else begin
            mag = r;
            if (dt == 4'h2) begin
                if (r[RES_W-1]) begin
                    s   = {s, "2d "};
                    mag = 0 - r;
                end else begin
                    s = {s, "2b "};
                end
            end
            for (int i = DIGITS - 1; i >= 0; i--) begin
                n = int'((mag >> (4 * i)) & 'hF);
                s = {s, $sformatf("%02h ", (n < 10) ? (48 + n) : (55 + n))};
            end
        end
        return {s, "0d 0a "};
    endfunction

    task automatic do_start(input logic [RES_W-1:0] r, input logic [3:0] dt, input logic e);
        start  = 1'b1;
        result = r;
        dtype  = dt;
        err    = e;
        @(negedge clk);
        start  = 1'b0;
        result = $urandom;
        dtype  = 4'($urandom);
        err    = 1'($urandom);
    endtask

    // Runs from a negedge until done is seen; records accepted bytes and
    // handshake-rule violations. Returns at the negedge where done is high.
    task automatic collect(input int ready_pct, input int inject_at,
                           output string got, output int cycles, output int proto_errs);
        logic       stalled;
        logic [7:0] held;
        got        = "";
        cycles     = -1;
        proto_errs = 0;
        stalled    = 1'b0;
        held       = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) begin
                cycles   = cyc;
                tx_ready = 1'b0;
                start    = 1'b0;
                return;
            end
            if (stalled && (!tx_valid || tx_data !== held)) proto_errs++;
            if (busy && !tx_valid) proto_errs++;
            if (cyc == inject_at) begin
                start  = 1'b1;
                result = $urandom;
                dtype  = 4'h2;
                err    = 1'b0;
            end else begin
                start = 1'b0;
            end
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (tx_valid && tx_ready) got = {got, $sformatf("%02h ", tx_data)};
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL collect_timeout: done not seen within 400 cycles, bytes so far: %s", got);
    endtask

    task automatic test_reset;
        n_rst    = 1'b0;
        start    = 1'b0;
        result   = '0;
        dtype    = 4'h1;
        err      = 1'b0;
        tx_ready = 1'b0;
        #12;
        vectors++;
        if ({tx_data, tx_valid, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got data=%02h valid=%b busy=%b done=%b, want 00 0 0 0",
                     tx_data, tx_valid, busy, done);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        string got, exp;
        int    cycles, perr;
        do_start(32'h0001E240, 4'h1, 1'b0);
        vectors++;
        if ({busy, tx_valid, tx_data} !== {1'b1, 1'b1, 8'h4F}) begin
            miscompares++;
            $display("FAIL first_byte_latency: got busy=%b valid=%b data=%02h, want 1 1 4f",
                     busy, tx_valid, tx_data);
        end
        collect(100, -1, got, cycles, perr);
        exp = model(32'h0001E240, 4'h1, 1'b0);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL unsigned_frame: got %s want %s", got, exp);
        end
        vectors++;
        if (cycles !== 12) begin
            miscompares++;
            $display("FAIL unsigned_timing: done after %0d cycles, want 12", cycles);
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, tx_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL done_single_pulse: got done=%b busy=%b valid=%b, want 0 0 0",
                     done, busy, tx_valid);
        end
    endtask

    task automatic test_directed_frames;
        logic [RES_W-1:0] rs[5]  = '{32'hFFFFFFFB, 32'h0000000C, 32'h12345678, 32'h80000000, 32'hABCDEF09};
        logic [3:0]       dts[5] = '{4'h2, 4'h2, 4'h1, 4'h2, 4'h7};
        logic             es[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        string got, exp;
        int    cycles, perr;
        for (int i = 0; i < 5; i++) begin
            do_start(rs[i], dts[i], es[i]);
            collect(100, -1, got, cycles, perr);
            exp = model(rs[i], dts[i], es[i]);
            vectors++;
            if (got != exp) begin
                miscompares++;
                $display("FAIL directed_frame_%0d: got %s want %s", i, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure;
        logic [RES_W-1:0] r;
        logic [3:0]       dt;
        logic             e;
        string got, exp;
        int    cycles, perr;
        for (int i = 0; i < 24; i++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       dt = 4'h1;
                1:       dt = 4'h2;
                default: dt = 4'($urandom);
            endcase
            e = ($urandom_range(0, 7) == 0);
            do_start(r, dt, e);
            collect(50, -1, got, cycles, perr);
            exp = model(r, dt, e);
            vectors++;
            if (got != exp) begin
                miscompares++;
                $display("FAIL backpressure_frame_%0d: r=%08h dt=%h e=%b got %s want %s",
                         i, r, dt, e, got, exp);
            end
            vectors++;
            if (perr !== 0) begin
                miscompares++;
                $display("FAIL backpressure_hold_%0d: %0d handshake violations, want 0", i, perr);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy;
        string got, exp;
        int    cycles, perr, idle_errs;
        do_start(32'h00C0FFEE, 4'h1, 1'b0);
        collect(100, 3, got, cycles, perr);
        exp = model(32'h00C0FFEE, 4'h1, 1'b0);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL start_while_busy_frame: got %s want %s", got, exp);
        end
        idle_errs = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || tx_valid) idle_errs++;
        end
        vectors++;
        if (idle_errs !== 0) begin
            miscompares++;
            $display("FAIL start_while_busy_no_second_frame: %0d active cycles, want 0", idle_errs);
        end
    endtask

    task automatic test_back_to_back;
        string got, exp;
        int    cycles, perr;
        do_start(32'h00000042, 4'h2, 1'b0);
        collect(100, -1, got, cycles, perr);
        do_start(32'hFFFFFF00, 4'h2, 1'b0);
        vectors++;
        if ({done, busy, tx_valid, tx_data} !== {1'b0, 1'b1, 1'b1, 8'h4F}) begin
            miscompares++;
            $display("FAIL start_on_done_launch: got done=%b busy=%b valid=%b data=%02h, want 0 1 1 4f",
                     done, busy, tx_valid, tx_data);
        end
        collect(70, -1, got, cycles, perr);
        exp = model(32'hFFFFFF00, 4'h2, 1'b0);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL start_on_done_frame: got %s want %s", got, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        string got, exp;
        int    cycles, perr;
        do_start(32'h13579BDF, 4'h2, 1'b0);
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);
        n_rst = 1'b0;
        #1;
        vectors++;
        if ({tx_data, tx_valid, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_frame: got data=%02h valid=%b busy=%b done=%b, want 00 0 0 0",
                     tx_data, tx_valid, busy, done);
        end
        tx_ready = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, tx_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_resume: got busy=%b valid=%b, want 0 0", busy, tx_valid);
        end
        do_start(32'h2468ACE0, 4'h1, 1'b0);
        collect(100, -1, got, cycles, perr);
        exp = model(32'h2468ACE0, 4'h1, 1'b0);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL post_reset_frame: got %s want %s", got, exp);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_directed_frames();
        test_backpressure();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
